// File: rtl/control_fsm_if.sv
// Control bundle between the multicycle control FSM and its datapath.
// The illegal_instr flag exists only when ILLEGAL_TRAP_EN is defined.
interface control_fsm_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       we_rf;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_control;
    logic [1:0] imm_src;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal_instr;
`endif

    modport master (
        input  op, funct3, funct7b5, zero,
`ifdef ILLEGAL_TRAP_EN
        output illegal_instr,
`endif
        output pc_write, adr_src, mem_write, ir_write, we_rf,
        output result_src, alu_src_a, alu_src_b, alu_control, imm_src
    );

    modport slave (
        output op, funct3, funct7b5, zero,
`ifdef ILLEGAL_TRAP_EN
        input  illegal_instr,
`endif
        input  pc_write, adr_src, mem_write, ir_write, we_rf,
        input  result_src, alu_src_a, alu_src_b, alu_control, imm_src
    );
endinterface

// File: rtl/control_fsm.sv
// Multicycle RISC-V control FSM (lw, sw, R-type, I-type ALU, jal, beq).
// Optional macro ILLEGAL_TRAP_EN adds a sticky ERROR state for unknown opcodes.
module control_fsm (
    input  logic            clk,
    input  logic            rst_n,
    control_fsm_if.master   bus
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
`ifdef ILLEGAL_TRAP_EN
        , S_ERROR  = 4'd11
`endif
    } state_t;

    state_t     state_r;
    state_t     state_next_s;

    logic       pc_write_s;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic       we_rf_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [2:0] alu_control_s;
    logic [1:0] imm_src_s;
    logic       illegal_s;

    // Subtract only for R-type with funct7 bit 5 set; I-type addi never subtracts.
    function automatic logic [2:0] funct_alu(input logic [6:0] op_v,
                                             input logic [2:0] f3,
                                             input logic       f7b5);
        case (f3)
            3'b000:  return (op_v[5] & f7b5) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic logic [1:0] imm_decode(input logic [6:0] op_v);
        case (op_v)
            OP_SW:   return 2'b01;
            OP_BEQ:  return 2'b10;
            OP_JAL:  return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    // State register; reset lands in FETCH asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and Moore output decode; everything is forced low while in reset.
    always_comb begin
        state_next_s  = state_r;
        pc_write_s    = 1'b0;
        adr_src_s     = 1'b0;
        mem_write_s   = 1'b0;
        ir_write_s    = 1'b0;
        we_rf_s       = 1'b0;
        result_src_s  = 2'b00;
        alu_src_a_s   = 2'b00;
        alu_src_b_s   = 2'b00;
        alu_control_s = 3'b000;
        imm_src_s     = 2'b00;
        illegal_s     = 1'b0;
        if (!rst_n) begin
            state_next_s = S_FETCH;
        end else begin
            imm_src_s = imm_decode(bus.op);
            case (state_r)
                S_FETCH: begin
                    ir_write_s   = 1'b1;
                    alu_src_b_s  = 2'b10;
                    result_src_s = 2'b10;
                    pc_write_s   = 1'b1;
                    state_next_s = S_DECODE;
                end
                S_DECODE: begin
                    alu_src_a_s = 2'b01;
                    alu_src_b_s = 2'b01;
                    case (bus.op)
                        OP_LW, OP_SW: state_next_s = S_MEMADR;
                        OP_R:         state_next_s = S_EXECUTER;
                        OP_I:         state_next_s = S_EXECUTEI;
                        OP_JAL:       state_next_s = S_JAL;
                        OP_BEQ:       state_next_s = S_BEQ;
`ifdef ILLEGAL_TRAP_EN
                        default:      state_next_s = S_ERROR;
`else
                        default:      state_next_s = S_FETCH;
`endif
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a_s = 2'b10;
                    alu_src_b_s = 2'b01;
                    if (bus.op == OP_LW) begin
                        state_next_s = S_MEMREAD;
                    end else begin
                        state_next_s = S_MEMWRITE;
                    end
                end
                S_MEMREAD: begin
                    adr_src_s    = 1'b1;
                    state_next_s = S_MEMWB;
                end
                S_MEMWB: begin
                    result_src_s = 2'b01;
                    we_rf_s      = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_MEMWRITE: begin
                    adr_src_s    = 1'b1;
                    mem_write_s  = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_EXECUTER: begin
                    alu_src_a_s   = 2'b10;
                    alu_control_s = funct_alu(bus.op, bus.funct3, bus.funct7b5);
                    state_next_s  = S_ALUWB;
                end
                S_EXECUTEI: begin
                    alu_src_a_s   = 2'b10;
                    alu_src_b_s   = 2'b01;
                    alu_control_s = funct_alu(bus.op, bus.funct3, bus.funct7b5);
                    state_next_s  = S_ALUWB;
                end
                S_ALUWB: begin
                    we_rf_s      = 1'b1;
                    state_next_s = S_FETCH;
                end
                S_JAL: begin
                    alu_src_a_s  = 2'b01;
                    alu_src_b_s  = 2'b10;
                    pc_write_s   = 1'b1;
                    state_next_s = S_ALUWB;
                end
                // Branch target was computed in DECODE; the compare result gates the PC load.
                S_BEQ: begin
                    alu_src_a_s   = 2'b10;
                    alu_control_s = 3'b001;
                    pc_write_s    = bus.zero;
                    state_next_s  = S_FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                S_ERROR: begin
                    illegal_s    = 1'b1;
                    state_next_s = S_ERROR;
                end
`endif
                default: begin
                    state_next_s = S_FETCH;
                end
            endcase
        end
    end

    assign bus.pc_write    = pc_write_s;
    assign bus.adr_src     = adr_src_s;
    assign bus.mem_write   = mem_write_s;
    assign bus.ir_write    = ir_write_s;
    assign bus.we_rf       = we_rf_s;
    assign bus.result_src  = result_src_s;
    assign bus.alu_src_a   = alu_src_a_s;
    assign bus.alu_src_b   = alu_src_b_s;
    assign bus.alu_control = alu_control_s;
    assign bus.imm_src     = imm_src_s;
`ifdef ILLEGAL_TRAP_EN
    assign bus.illegal_instr = illegal_s;
`else
    logic unused_illegal_s;
    assign unused_illegal_s = illegal_s;
`endif

endmodule

// File: tb/tb_control_fsm.sv
// Self-checking bench for control_fsm: an instruction-level schedule model plus directed checks.
module tb_control_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic       we_rf;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_control;
        logic [1:0] imm_src;
        logic       illegal;
    } ctl_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    ctl_t dut_s;
    ctl_t exp_q[$];
    string name_q[$];

    control_fsm_if bus ();

    control_fsm dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic ill_s;
`ifdef ILLEGAL_TRAP_EN
    assign ill_s = bus.illegal_instr;
`else
    assign ill_s = 1'b0;
`endif
    assign dut_s = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write, bus.we_rf,
                    bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.alu_control,
                    bus.imm_src, ill_s};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] imm_of(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [2:0] alu_of(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        if (f3 == 3'b010) return 3'b101;
        if (f3 == 3'b110) return 3'b011;
        if (f3 == 3'b111) return 3'b010;
        if (f3 == 3'b000 && o[5] && f7) return 3'b001;
        return 3'b000;
    endfunction

    function automatic ctl_t idle(input logic [1:0] imm);
        ctl_t c;
        c = '0;
        c.imm_src = imm;
        return c;
    endfunction

    task automatic push(input ctl_t c, input string nm);
        exp_q.push_back(c);
        name_q.push_back(nm);
    endtask

    // Cycle-by-cycle expectation schedule of one instruction, derived from its class.
    task automatic build(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        ctl_t c;
        logic [1:0] imm;
        imm = imm_of(o);
        c = idle(imm); c.ir_write = 1'b1; c.alu_src_b = 2'b10; c.result_src = 2'b10; c.pc_write = 1'b1;
        push(c, "fetch");
        c = idle(imm); c.alu_src_a = 2'b01; c.alu_src_b = 2'b01;
        push(c, "decode");
        if (o == 7'b0000011 || o == 7'b0100011) begin
            c = idle(imm); c.alu_src_a = 2'b10; c.alu_src_b = 2'b01;
            push(c, "memadr");
            c = idle(imm); c.adr_src = 1'b1;
            if (o == 7'b0000011) begin
                push(c, "memread");
                c = idle(imm); c.result_src = 2'b01; c.we_rf = 1'b1;
                push(c, "memwb");
            end else begin
                c.mem_write = 1'b1;
                push(c, "memwrite");
            end
        end else if (o == 7'b0110011 || o == 7'b0010011) begin
            c = idle(imm); c.alu_src_a = 2'b10; c.alu_src_b = (o == 7'b0010011) ? 2'b01 : 2'b00;
            c.alu_control = alu_of(o, f3, f7);
            push(c, "execute");
            c = idle(imm); c.we_rf = 1'b1;
            push(c, "aluwb");
        end else if (o == 7'b1101111) begin
            c = idle(imm); c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1'b1;
            push(c, "jal");
            c = idle(imm); c.we_rf = 1'b1;
            push(c, "aluwb");
        end else if (o == 7'b1100011) begin
            c = idle(imm); c.alu_src_a = 2'b10; c.alu_control = 3'b001; c.pc_write = z;
            push(c, "beq");
        end
    endtask

    task automatic set_in(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        bus.op = o; bus.funct3 = f3; bus.funct7b5 = f7; bus.zero = z;
    endtask

    task automatic drain();
        int n;
        n = exp_q.size();
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z);
        set_in(o, f3, f7, z);
        build(o, f3, f7, z);
        drain();
    endtask

    task automatic pin(input string nm, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, got, want);
        end
    endtask

    task automatic check_zero(input string nm);
        checks++;
        if (dut_s !== '0) begin
            errors++;
            $display("FAIL %s: got %h expected 0", nm, dut_s);
        end
    endtask

    // Compare process: every scheduled cycle is checked on the falling edge.
    always @(negedge clk) begin : cmp
        ctl_t  e;
        string nm;
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            checks++;
            if (dut_s !== e) begin
                errors++;
                $display("FAIL %s: got %h expected %h", nm, dut_s, e);
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        set_in(7'b0100011, 3'b000, 1'b0, 1'b0);
        #3;
        check_zero("reset_before_clock");
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset_with_clock");
        rst_n = 1'b1;

        // lw: 5 cycles, writeback from memory data in cycle 5 only
        set_in(7'b0000011, 3'b010, 1'b0, 1'b0);
        build(7'b0000011, 3'b010, 1'b0, 1'b0);
        pin("lw_len", exp_q.size(), 5);
        pin("lw_c5_we", exp_q[4].we_rf, 1);
        pin("lw_c5_rs", exp_q[4].result_src, 1);
        drain();

        set_in(7'b0100011, 3'b010, 1'b0, 1'b0);
        build(7'b0100011, 3'b010, 1'b0, 1'b0);
        pin("sw_len", exp_q.size(), 4);
        pin("sw_c4_mw", exp_q[3].mem_write, 1);
        pin("sw_imm", exp_q[0].imm_src, 1);
        drain();

        set_in(7'b0110011, 3'b000, 1'b1, 1'b0);
        build(7'b0110011, 3'b000, 1'b1, 1'b0);
        pin("sub_alu", exp_q[2].alu_control, 1);
        drain();
        run(7'b0110011, 3'b000, 1'b0, 1'b0);
        run(7'b0110011, 3'b110, 1'b0, 1'b0);
        run(7'b0110011, 3'b010, 1'b0, 1'b1);
        run(7'b0110011, 3'b111, 1'b1, 1'b0);
        run(7'b0110011, 3'b001, 1'b1, 1'b0);

        // addi with bit 30 set must still add
        set_in(7'b0010011, 3'b000, 1'b1, 1'b0);
        build(7'b0010011, 3'b000, 1'b1, 1'b0);
        pin("addi_alu", exp_q[2].alu_control, 0);
        drain();
        run(7'b0010011, 3'b111, 1'b0, 1'b0);
        run(7'b0010011, 3'b010, 1'b0, 1'b0);

        set_in(7'b1101111, 3'b000, 1'b0, 1'b0);
        build(7'b1101111, 3'b000, 1'b0, 1'b0);
        pin("jal_len", exp_q.size(), 4);
        drain();

        set_in(7'b1100011, 3'b000, 1'b0, 1'b1);
        build(7'b1100011, 3'b000, 1'b0, 1'b1);
        pin("beq_len", exp_q.size(), 3);
        pin("beq_taken_pcw", exp_q[2].pc_write, 1);
        drain();
        run(7'b1100011, 3'b000, 1'b0, 1'b0);

        // unknown opcode
        set_in(7'b1111111, 3'b000, 1'b0, 1'b0);
        build(7'b1111111, 3'b000, 1'b0, 1'b0);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 4; i++) begin
            ctl_t c;
            c = '0;
            c.illegal = 1'b1;
            push(c, "error");
        end
        drain();
        rst_n = 1'b0;
        #1;
        check_zero("error_cleared_by_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`else
        drain();
`endif
        run(7'b0010011, 3'b110, 1'b0, 1'b0);

        // reset during MEMREAD abandons the load
        set_in(7'b0000011, 3'b000, 1'b0, 1'b0);
        build(7'b0000011, 3'b000, 1'b0, 1'b0);
        void'(exp_q.pop_back());
        void'(name_q.pop_back());
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_zero("reset_mid_instr");
        @(posedge clk);
        #1;
        check_zero("reset_mid_held");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        run(7'b0110011, 3'b000, 1'b1, 1'b0);

        pin("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
